// File: rtl/sprite_fetch_arbiter_pkg.sv
// Shared types and constants for the sprite-position fetch arbiter.
package sprite_fetch_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMMIT
    } fetch_state_t;

    // Word slots within the committed sprite-position block.
    localparam int unsigned LIFE_X  = 0;
    localparam int unsigned LIFE_Y  = 1;
    localparam int unsigned BOMB_X  = 2;
    localparam int unsigned BOMB_Y  = 3;
    localparam int unsigned ENEMY_X = 4;
    localparam int unsigned ENEMY_Y = 5;

    localparam int unsigned SPRITE_WORDS     = ENEMY_Y + 1;
    localparam logic [31:0] SPRITE_BASE_ADDR = 32'h0000_0100;

endpackage

// File: rtl/sprite_fetch_arbiter.sv
// Shares the data-memory port between the CPU and a once-per-frame sprite
// position fetcher. The CPU always wins the port; the fetcher reads only in
// idle cycles and publishes the whole block atomically on commit.
module sprite_fetch_arbiter
    import sprite_fetch_arbiter_pkg::*;
#(
    parameter int unsigned          NUM_WORDS = SPRITE_WORDS,
    parameter int unsigned          DATA_W    = 32,
    parameter logic [DATA_W-1:0]    BASE_ADDR = DATA_W'(SPRITE_BASE_ADDR)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [DATA_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_wdata,
    input  logic                          frame_start,
    output logic [DATA_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_we,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [NUM_WORDS*DATA_W-1:0]   sprite_pos,
    output logic                          pos_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int unsigned      IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    fetch_state_t                        state;
    logic [IDX_W-1:0]                    idx;
    logic [IDX_W-1:0]                    tag_idx;
    logic                                fv;
    logic                                fetch_issue;
    logic [NUM_WORDS-1:0][DATA_W-1:0]    shadow;
    logic [NUM_WORDS-1:0][DATA_W-1:0]    shadow_next;
    logic [NUM_WORDS-1:0][DATA_W-1:0]    pos_q;

    assign sprite_pos = pos_q;

    // Port mux: CPU has priority, fetcher reads only in cycles the CPU leaves free.
    always_comb begin
        fetch_issue = (state == FETCH) && !cpu_req && !reset;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        if (cpu_req) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else if (fetch_issue) begin
            mem_addr = BASE_ADDR + (DATA_W'(idx) << 2);
        end
    end

    // Shadow copy including the read returning this cycle, if it is a fetcher read.
    always_comb begin
        shadow_next = shadow;
        if (fv) begin
            shadow_next[tag_idx] = mem_rdata;
        end
    end

    // Fetch FSM, return capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            tag_idx   <= '0;
            fv        <= 1'b0;
            shadow    <= '0;
            pos_q     <= '0;
            pos_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            pos_valid <= 1'b0;
            shadow    <= shadow_next;
            fv        <= fetch_issue;
            tag_idx   <= idx;
            if (frame_start && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= FETCH;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (fetch_issue) begin
                        if (idx == LAST_IDX) begin
                            state <= DRAIN;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The last word lands in the same edge that enters COMMIT, so the
                    // published block is taken from shadow_next to keep the outputs
                    // registered yet coincident with the COMMIT cycle.
                    state     <= COMMIT;
                    pos_q     <= shadow_next;
                    pos_valid <= 1'b1;
                    busy      <= 1'b0;
                end
                COMMIT: begin
                    if (frame_start) begin
                        state <= FETCH;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Self-checking bench for sprite_fetch_arbiter: directed vector table, corner
// sequences, and randomized traffic against a transaction-level model.
module tb_sprite_fetch_arbiter;
    import sprite_fetch_arbiter_pkg::*;

    localparam int          NW   = SPRITE_WORDS;
    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic                 clk = 1'b0;
    logic                 reset, cpu_req, cpu_we, frame_start;
    logic [DW-1:0]        cpu_addr, cpu_wdata;
    logic [DW-1:0]        mem_addr, mem_wdata, mem_rdata;
    logic                 mem_we;
    logic [NW*DW-1:0]     sprite_pos;
    logic                 pos_valid, busy, overrun;

    always #5 clk = ~clk;

    sprite_fetch_arbiter #(
        .NUM_WORDS (NW),
        .DATA_W    (DW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .frame_start (frame_start),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .sprite_pos  (sprite_pos),
        .pos_valid   (pos_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    // Data memory: synchronous read, data valid one cycle after the address.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:2]];
    end

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a frame is a list of NW reads taken in CPU-free cycles;
    // the block appears two cycles after the last read.
    bit          m_active, m_overrun, fetch_now;
    int          m_issued, m_commit, m_cycle;
    logic [31:0] m_vals  [NW];
    logic [31:0] m_shown [NW];
    logic [31:0] rd_val;

    typedef struct {
        logic        req, we;
        logic [31:0] addr, wdata;
        logic        fs;
        logic [31:0] e_addr;
        logic        e_we, e_busy, e_pv;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cycle);
        end
    endtask

    task automatic model_clear();
        m_active  = 1'b0;
        m_overrun = 1'b0;
        m_issued  = 0;
        m_commit  = -10;
        for (int i = 0; i < NW; i++) begin
            m_vals[i]  = '0;
            m_shown[i] = '0;
        end
    endtask

    // Drive one cycle's inputs, then check every output mid-cycle against the model.
    task automatic drive_check(input logic rq, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic fs, input logic rst);
        logic [31:0] exp_addr;
        cpu_req     = rq;
        cpu_we      = w;
        cpu_addr    = a;
        cpu_wdata   = d;
        frame_start = fs;
        reset       = rst;
        @(negedge clk);
        fetch_now = m_active && (m_issued < NW) && !rq && !rst;
        exp_addr  = rq ? a : (fetch_now ? BASE + 32'(4 * m_issued) : 32'h0);
        chk("mem_addr",  mem_addr,  exp_addr);
        chk("mem_we",    mem_we,    rq & w);
        chk("mem_wdata", mem_wdata, rq ? d : 32'h0);
        chk("busy",      busy,      m_active);
        chk("pos_valid", pos_valid, m_cycle == m_commit);
        chk("overrun",   overrun,   m_overrun);
        for (int i = 0; i < NW; i++)
            chk("sprite_pos", sprite_pos[i*DW +: DW], m_shown[i]);
        rd_val = mem[exp_addr[7:2]];
    endtask

    // Cross the clock edge and advance the model with the inputs just applied.
    task automatic advance();
        bit busy_k;
        @(posedge clk);
        #1;
        if (reset) begin
            model_clear();
        end else begin
            busy_k = m_active;
            if (fetch_now) begin
                m_vals[m_issued] = rd_val;
                m_issued++;
                if (m_issued == NW) m_commit = m_cycle + 2;
            end
            if (m_cycle == m_commit - 1) begin
                m_shown  = m_vals;
                m_active = 1'b0;
            end
            if (frame_start) begin
                if (busy_k) m_overrun = 1'b1;
                else begin
                    m_active = 1'b1;
                    m_issued = 0;
                end
            end
        end
        m_cycle++;
    endtask

    task automatic step(input logic rq, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic fs, input logic rst);
        drive_check(rq, w, a, d, fs, rst);
        advance();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Idle until pos_valid is seen; at = cycles waited, or -1 if the budget ran out.
    task automatic wait_pv(input int budget, output int at);
        at = -1;
        for (int j = 1; j <= budget; j++) begin
            drive_check(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            if (pos_valid) at = j;
            advance();
            if (at >= 0) break;
        end
    endtask

    function automatic vec_t mk(input logic rq, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic fs, input logic [31:0] ea,
                                input logic ew, input logic eb, input logic ep);
        vec_t v;
        v.req = rq; v.we = w; v.addr = a; v.wdata = d; v.fs = fs;
        v.e_addr = ea; v.e_we = ew; v.e_busy = eb; v.e_pv = ep;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int at;
        int pvc;
        logic rq;

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; frame_start = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        m_cycle = 0;
        model_clear();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Reset state.
        chk("rst_busy",      busy,       1'b0);
        chk("rst_pos_valid", pos_valid,  1'b0);
        chk("rst_overrun",   overrun,    1'b0);
        chk("rst_sprite",    sprite_pos == '0, 1'b1);

        // Directed table: CPU access, memory preload, then one undisturbed frame.
        tbl.push_back(mk(1, 1, 32'h40, 32'h55, 0, 32'h40, 1, 0, 0));
        for (int i = 0; i < NW; i++)
            tbl.push_back(mk(1, 1, BASE + 32'(4*i), 32'(i+1), 0, BASE + 32'(4*i), 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 0, 0, 0));
        for (int i = 0; i < NW; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, BASE + 32'(4*i), 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        foreach (tbl[k]) begin
            drive_check(tbl[k].req, tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].fs, 1'b0);
            chk("tbl_addr",      mem_addr,  tbl[k].e_addr);
            chk("tbl_we",        mem_we,    tbl[k].e_we);
            chk("tbl_busy",      busy,      tbl[k].e_busy);
            chk("tbl_pos_valid", pos_valid, tbl[k].e_pv);
            advance();
        end
        for (int i = 0; i < NW; i++)
            chk("frame1_word", sprite_pos[i*DW +: DW], 32'(i+1));

        // CPU reads on alternate cycles during the fetch.
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        at = -1;
        for (int j = 1; j <= 40; j++) begin
            rq = ((j % 2) == 1) && (j <= 11);
            drive_check(rq, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
            if (pos_valid) at = j;
            advance();
            if (at >= 0) break;
        end
        chk("alt_pv_latency", at, 14);
        for (int i = 0; i < NW; i++)
            chk("alt_word", sprite_pos[i*DW +: DW], 32'(i+1));

        // CPU store between frames stays invisible until the next commit.
        step(1'b1, 1'b1, 32'h104, 32'd99, 1'b0, 1'b0);
        repeat (3) idle();
        chk("hold_word1", sprite_pos[LIFE_Y*DW +: DW], 32'd2);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        wait_pv(20, at);
        chk("store_pv_latency", at, 8);
        chk("store_word1", sprite_pos[LIFE_Y*DW +: DW], 32'd99);
        chk("store_word0", sprite_pos[LIFE_X*DW +: DW], 32'd1);

        // Second frame_start while busy: overrun, one commit only.
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        pvc = 0;
        for (int j = 0; j < 20; j++) begin
            drive_check(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            if (pos_valid) pvc++;
            advance();
        end
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_single_pv", pvc, 1);

        // Reset in the middle of a fetch, with idx at 3.
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (3) idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("midrst_sprite",  sprite_pos == '0, 1'b1);
        chk("midrst_overrun", overrun, 1'b0);
        chk("midrst_busy",    busy,    1'b0);
        pvc = 0;
        for (int j = 0; j < 15; j++) begin
            drive_check(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            if (pos_valid) pvc++;
            advance();
        end
        chk("midrst_no_pv", pvc, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic        r_rq, r_w, r_fs, r_rst;
            logic [31:0] r_a;
            r_rq  = ($urandom_range(0, 9) < 4);
            r_w   = 1'($urandom_range(0, 1));
            r_a   = ($urandom_range(0, 1) == 1) ? BASE + 32'(4 * $urandom_range(0, 7))
                                                : 32'(4 * $urandom_range(0, 63));
            r_fs  = ($urandom_range(0, 11) == 0);
            r_rst = ($urandom_range(0, 499) == 0);
            step(r_rq, r_w, r_a, $urandom, r_fs, r_rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
